// File: rtl/dryer_actuator_seq.sv
// Safety sequencer between the dryer controller and the motor/heater relays:
// spin-up before heat, rate-limited heat ramp, cool-down run, door/over-temp interlocks.

module dryer_actuator_seq_chk (
   input logic       CLK,
   input logic       RESET_N,
   input logic       MTR_DRV,
   input logic [0:1] HTR_DRV,
   input logic       FAULT
);

   heater_needs_motor: assert property (@(posedge CLK) disable iff (!RESET_N)
      (HTR_DRV != 2'b00) |-> MTR_DRV);

   no_heat_in_fault: assert property (@(posedge CLK) disable iff (!RESET_N)
      FAULT |-> (HTR_DRV == 2'b00));

endmodule

module dryer_actuator_seq #(
   parameter int CLK_PER_SEC  = 50000,
   parameter int SPINUP_SEC   = 2,
   parameter int COOLDOWN_SEC = 5,
   parameter int SEC_W        = 8
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       MTR_REQ,
   input  logic [0:1] HTR_REQ,
   input  logic       DOOR_OPEN,
   input  logic       OVERTEMP,
   input  logic       FAULT_CLR,
   output logic       MTR_DRV,
   output logic [0:1] HTR_DRV,
   output logic       COOLING,
   output logic       FAULT
);

   localparam int PRE_W = $clog2(CLK_PER_SEC);

   localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(CLK_PER_SEC - 1);
   localparam logic [SEC_W-1:0] SEC_ZERO = {SEC_W{1'b0}};
   localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
   localparam logic [SEC_W-1:0] SEC_SPIN = SEC_W'(SPINUP_SEC);
   localparam logic [SEC_W-1:0] SEC_COOL = SEC_W'(COOLDOWN_SEC);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SPINUP   = 3'd1,
      ST_RUN      = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             door_meta_r;
   logic             door_sync_r;
   logic             temp_meta_r;
   logic             temp_sync_r;
   logic [PRE_W-1:0] presc_r;
   logic [SEC_W-1:0] sec_r;
   logic [SEC_W-1:0] sec_load_s;
   logic             sec_tick_s;
   logic             expire_s;
   logic             heat_used_r;
   logic             heat_seen_s;
   logic [0:1]       ramp_s;
   logic             mtr_drv_r;
   logic [0:1]       htr_drv_r;
   logic             cooling_r;
   logic             fault_r;
   logic             mtr_nxt_s;
   logic [0:1]       htr_nxt_s;
   logic             cool_nxt_s;
   logic             fault_nxt_s;

   assign sec_tick_s  = (presc_r == PRE_TC);
   // A timed state ends on its last tick, or after one cycle when loaded with zero.
   assign expire_s    = (sec_r == SEC_ZERO) || (sec_tick_s && (sec_r == SEC_ONE));
   assign heat_seen_s = heat_used_r || (htr_drv_r != 2'b00);

   // Two-flop synchronizers for the asynchronous door and thermal inputs
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         door_meta_r <= 1'b0;
         door_sync_r <= 1'b0;
         temp_meta_r <= 1'b0;
         temp_sync_r <= 1'b0;
      end else begin
         door_meta_r <= DOOR_OPEN;
         door_sync_r <= door_meta_r;
         temp_meta_r <= OVERTEMP;
         temp_sync_r <= temp_meta_r;
      end
   end

   // State register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; interlocks are checked ahead of normal sequencing
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (temp_sync_r) begin
               state_nxt_s = ST_FAULT;
            end else if (MTR_REQ && !door_sync_r) begin
               state_nxt_s = ST_SPINUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SPINUP: begin
            if (temp_sync_r) begin
               state_nxt_s = ST_FAULT;
            end else if (door_sync_r || !MTR_REQ) begin
               state_nxt_s = ST_IDLE;
            end else if (expire_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_SPINUP;
            end
         end
         ST_RUN: begin
            if (temp_sync_r) begin
               state_nxt_s = ST_FAULT;
            end else if (door_sync_r) begin
               state_nxt_s = ST_IDLE;
            end else if (!MTR_REQ) begin
               state_nxt_s = heat_seen_s ? ST_COOLDOWN : ST_IDLE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_COOLDOWN: begin
            if (temp_sync_r) begin
               state_nxt_s = ST_FAULT;
            end else if (door_sync_r) begin
               state_nxt_s = ST_IDLE;
            end else if (MTR_REQ) begin
               state_nxt_s = ST_RUN;
            end else if (expire_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_COOLDOWN;
            end
         end
         ST_FAULT: begin
            if (FAULT_CLR && !temp_sync_r) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_FAULT;
            end
         end
         default: state_nxt_s = ST_FAULT;
      endcase
   end

   // Seconds counter reload value for the state being entered
   always_comb begin
      case (state_nxt_s)
         ST_SPINUP:   sec_load_s = SEC_SPIN;
         ST_COOLDOWN: sec_load_s = SEC_COOL;
         ST_FAULT:    sec_load_s = SEC_COOL;
         default:     sec_load_s = SEC_ZERO;
      endcase
   end

   // Prescaler and seconds counter, both restarted on every state change
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         presc_r <= PRE_ZERO;
         sec_r   <= SEC_ZERO;
      end else if (state_nxt_s != state_r) begin
         presc_r <= PRE_ZERO;
         sec_r   <= sec_load_s;
      end else begin
         presc_r <= sec_tick_s ? PRE_ZERO : (presc_r + PRE_ONE);
         if (sec_tick_s && (sec_r != SEC_ZERO)) begin
            sec_r <= sec_r - SEC_ONE;
         end else begin
            sec_r <= sec_r;
         end
      end
   end

   // Heater ramp: drops follow immediately, rises take one level per second
   always_comb begin
      if (HTR_REQ < htr_drv_r) begin
         ramp_s = HTR_REQ;
      end else if ((HTR_REQ > htr_drv_r) && sec_tick_s) begin
         ramp_s = htr_drv_r + 2'b01;
      end else begin
         ramp_s = htr_drv_r;
      end
   end

   // Output values for the upcoming state
   always_comb begin
      mtr_nxt_s   = 1'b0;
      htr_nxt_s   = 2'b00;
      cool_nxt_s  = 1'b0;
      fault_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_IDLE: begin
            mtr_nxt_s = 1'b0;
         end
         ST_SPINUP: begin
            mtr_nxt_s = 1'b1;
         end
         ST_RUN: begin
            mtr_nxt_s = 1'b1;
            htr_nxt_s = (state_r == ST_RUN) ? ramp_s : 2'b00;
         end
         ST_COOLDOWN: begin
            mtr_nxt_s  = 1'b1;
            cool_nxt_s = 1'b1;
         end
         ST_FAULT: begin
            fault_nxt_s = 1'b1;
            mtr_nxt_s   = !door_sync_r && ((state_r != ST_FAULT) || !expire_s);
         end
         default: begin
            fault_nxt_s = 1'b1;
         end
      endcase
   end

   // Registered relay outputs and heat history
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mtr_drv_r   <= 1'b0;
         htr_drv_r   <= 2'b00;
         cooling_r   <= 1'b0;
         fault_r     <= 1'b0;
         heat_used_r <= 1'b0;
      end else begin
         mtr_drv_r <= mtr_nxt_s;
         htr_drv_r <= htr_nxt_s;
         cooling_r <= cool_nxt_s;
         fault_r   <= fault_nxt_s;
         if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_FAULT)) begin
            heat_used_r <= 1'b0;
         end else begin
            heat_used_r <= heat_seen_s;
         end
      end
   end

   assign MTR_DRV = mtr_drv_r;
   assign HTR_DRV = htr_drv_r;
   assign COOLING = cooling_r;
   assign FAULT   = fault_r;

   dryer_actuator_seq_chk u_chk (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .MTR_DRV (mtr_drv_r),
      .HTR_DRV (htr_drv_r),
      .FAULT   (fault_r)
   );

endmodule

// File: tb/tb_dryer_actuator_seq.sv
// Bench for dryer_actuator_seq: directed scenarios with literal checks plus
// random stimulus, all compared every cycle against a cycle-count reference model.

module tb_dryer_actuator_seq;

   localparam int CPS  = 10;
   localparam int SPIN = 2;
   localparam int COOL = 3;

   localparam int P_IDLE  = 0;
   localparam int P_SPIN  = 1;
   localparam int P_RUN   = 2;
   localparam int P_COOL  = 3;
   localparam int P_FAULT = 4;

   logic       CLK       = 1'b0;
   logic       RESET_N   = 1'b0;
   logic       MTR_REQ   = 1'b0;
   logic [0:1] HTR_REQ   = 2'b00;
   logic       DOOR_OPEN = 1'b0;
   logic       OVERTEMP  = 1'b0;
   logic       FAULT_CLR = 1'b0;
   logic       MTR_DRV;
   logic [0:1] HTR_DRV;
   logic       COOLING;
   logic       FAULT;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   dryer_actuator_seq #(
      .CLK_PER_SEC  (CPS),
      .SPINUP_SEC   (SPIN),
      .COOLDOWN_SEC (COOL),
      .SEC_W        (8)
   ) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .MTR_REQ   (MTR_REQ),
      .HTR_REQ   (HTR_REQ),
      .DOOR_OPEN (DOOR_OPEN),
      .OVERTEMP  (OVERTEMP),
      .FAULT_CLR (FAULT_CLR),
      .MTR_DRV   (MTR_DRV),
      .HTR_DRV   (HTR_DRV),
      .COOLING   (COOLING),
      .FAULT     (FAULT)
   );

   // ---------------- reference model ----------------
   int         m_phase = P_IDLE;
   int         m_age   = 0;      // cycles spent in the current phase
   logic       m_heat  = 1'b0;
   logic [1:0] m_dh    = 2'b00;  // [0] first stage, [1] synchronized value
   logic [1:0] m_th    = 2'b00;
   logic       e_mtr   = 1'b0;
   logic [0:1] e_htr   = 2'b00;
   logic       e_cool  = 1'b0;
   logic       e_fault = 1'b0;

   function automatic int dur(input int secs);
      return (secs == 0) ? 1 : secs * CPS;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_age   = 0;
      m_heat  = 1'b0;
      m_dh    = 2'b00;
      m_th    = 2'b00;
      e_mtr   = 1'b0;
      e_htr   = 2'b00;
      e_cool  = 1'b0;
      e_fault = 1'b0;
   endtask

   task automatic model_step();
      int   nxt;
      logic ds;
      logic ts;
      logic tick;
      logic entered;
      ds   = m_dh[1];
      ts   = m_th[1];
      m_dh = {m_dh[0], DOOR_OPEN};
      m_th = {m_th[0], OVERTEMP};
      m_age = m_age + 1;
      tick  = ((m_age % CPS) == 0);
      nxt   = m_phase;
      if (m_phase != P_FAULT && ts) begin
         nxt = P_FAULT;
      end else if ((m_phase == P_SPIN || m_phase == P_RUN || m_phase == P_COOL) && ds) begin
         nxt = P_IDLE;
      end else begin
         case (m_phase)
            P_IDLE:  if (MTR_REQ && !ds) nxt = P_SPIN;
            P_SPIN:  if (!MTR_REQ) nxt = P_IDLE; else if (m_age >= dur(SPIN)) nxt = P_RUN;
            P_RUN:   if (!MTR_REQ) nxt = (m_heat || e_htr != 2'b00) ? P_COOL : P_IDLE;
            P_COOL:  if (MTR_REQ) nxt = P_RUN; else if (m_age >= dur(COOL)) nxt = P_IDLE;
            P_FAULT: if (FAULT_CLR && !ts) nxt = P_IDLE;
            default: nxt = P_IDLE;
         endcase
      end
      entered = (nxt != m_phase);
      if (nxt == P_IDLE || nxt == P_FAULT) m_heat = 1'b0;
      else if (e_htr != 2'b00) m_heat = 1'b1;
      e_cool  = (nxt == P_COOL);
      e_fault = (nxt == P_FAULT);
      e_mtr   = (nxt == P_SPIN || nxt == P_RUN || nxt == P_COOL);
      if (nxt == P_FAULT) e_mtr = !ds && (entered || m_age < dur(COOL));
      if (nxt != P_RUN || entered) e_htr = 2'b00;
      else if (HTR_REQ < e_htr) e_htr = HTR_REQ;
      else if (HTR_REQ > e_htr && tick) e_htr = e_htr + 2'b01;
      if (entered) m_age = 0;
      m_phase = nxt;
   endtask

   initial begin
      forever begin
         @(posedge CLK or negedge RESET_N);
         if (!RESET_N) model_reset();
         else model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      chk("model_MTR_DRV", int'(MTR_DRV), int'(e_mtr));
      chk("model_HTR_DRV", int'(HTR_DRV), int'(e_htr));
      chk("model_COOLING", int'(COOLING), int'(e_cool));
      chk("model_FAULT",   int'(FAULT),   int'(e_fault));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      cyc(3);
      chk("reset_mtr", int'(MTR_DRV), 0);
      chk("reset_htr", int'(HTR_DRV), 0);
      chk("reset_fault", int'(FAULT), 0);
      RESET_N = 1'b1;
      cyc(2);

      // 1: nominal start with ramp
      MTR_REQ = 1'b1; HTR_REQ = 2'b11;
      cyc(1);
      chk("t1_mtr_on", int'(MTR_DRV), 1);
      chk("t1_htr_spin", int'(HTR_DRV), 0);
      cyc(29);
      chk("t1_htr_pre_step", int'(HTR_DRV), 0);
      cyc(1);
      chk("t1_htr_step1", int'(HTR_DRV), 1);
      cyc(10);
      chk("t1_htr_step2", int'(HTR_DRV), 2);
      cyc(10);
      chk("t1_htr_step3", int'(HTR_DRV), 3);

      // 2: stop with cool-down
      MTR_REQ = 1'b0;
      cyc(1);
      chk("t2_htr_off", int'(HTR_DRV), 0);
      chk("t2_cooling", int'(COOLING), 1);
      cyc(29);
      chk("t2_mtr_still_on", int'(MTR_DRV), 1);
      cyc(1);
      chk("t2_mtr_off", int'(MTR_DRV), 0);
      chk("t2_cooling_off", int'(COOLING), 0);

      // 3: unheated stop
      MTR_REQ = 1'b1; HTR_REQ = 2'b00;
      cyc(26);
      MTR_REQ = 1'b0;
      cyc(1);
      chk("t3_mtr_off", int'(MTR_DRV), 0);
      chk("t3_no_cooling", int'(COOLING), 0);

      // 4: door interlock
      MTR_REQ = 1'b1; HTR_REQ = 2'b10;
      cyc(41);
      chk("t4_htr_med", int'(HTR_DRV), 2);
      DOOR_OPEN = 1'b1;
      cyc(3);
      chk("t4_door_mtr_off", int'(MTR_DRV), 0);
      chk("t4_door_htr_off", int'(HTR_DRV), 0);
      cyc(5);
      DOOR_OPEN = 1'b0;
      cyc(2);
      chk("t4_still_idle", int'(MTR_DRV), 0);
      cyc(1);
      chk("t4_respin", int'(MTR_DRV), 1);

      // 5: over-temperature fault
      cyc(25);
      OVERTEMP = 1'b1;
      cyc(3);
      chk("t5_fault", int'(FAULT), 1);
      chk("t5_htr_off", int'(HTR_DRV), 0);
      chk("t5_mtr_on", int'(MTR_DRV), 1);
      cyc(29);
      chk("t5_mtr_still_on", int'(MTR_DRV), 1);
      cyc(1);
      chk("t5_mtr_off", int'(MTR_DRV), 0);
      FAULT_CLR = 1'b1;
      cyc(1);
      FAULT_CLR = 1'b0;
      chk("t5_clr_ignored", int'(FAULT), 1);
      OVERTEMP = 1'b0;
      cyc(2);
      FAULT_CLR = 1'b1;
      cyc(1);
      FAULT_CLR = 1'b0;
      chk("t5_cleared", int'(FAULT), 0);
      chk("t5_idle_mtr", int'(MTR_DRV), 0);

      // 6: asynchronous reset mid-run
      MTR_REQ = 1'b0;
      cyc(2);
      MTR_REQ = 1'b1; HTR_REQ = 2'b11;
      cyc(51);
      chk("t6_htr_hi", int'(HTR_DRV), 3);
      #2 RESET_N = 1'b0;
      #1;
      chk("t6_rst_mtr", int'(MTR_DRV), 0);
      chk("t6_rst_htr", int'(HTR_DRV), 0);
      chk("t6_rst_cool", int'(COOLING), 0);
      chk("t6_rst_fault", int'(FAULT), 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      cyc(1);
      chk("t6_respin_mtr", int'(MTR_DRV), 1);
      cyc(29);
      chk("t6_respin_htr", int'(HTR_DRV), 0);
      cyc(1);
      chk("t6_ramp_again", int'(HTR_DRV), 1);

      // random stimulus, checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         @(negedge CLK);
         FAULT_CLR = ($urandom_range(9, 0) == 0);
         if ($urandom_range(59, 0) == 0) MTR_REQ = ~MTR_REQ;
         if ($urandom_range(39, 0) == 0) HTR_REQ = 2'($urandom_range(3, 0));
         if (DOOR_OPEN) begin
            if ($urandom_range(14, 0) == 0) DOOR_OPEN = 1'b0;
         end else begin
            if ($urandom_range(149, 0) == 0) DOOR_OPEN = 1'b1;
         end
         if (OVERTEMP) begin
            if ($urandom_range(29, 0) == 0) OVERTEMP = 1'b0;
         end else begin
            if ($urandom_range(399, 0) == 0) OVERTEMP = 1'b1;
         end
      end

      cyc(1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dryer_actuator_seq.md
Name: dryer_actuator_seq

Overview:
- Sits directly downstream of the dryer controller FSM: consumes its MTR / HTR[0:1] requests and drives the physical motor and heater relays.
- Enforces the safety sequencing the controller does not:
  - motor spin-up before any heat
  - heat ramp-up one step at a time
  - motor cool-down run after heat is removed
  - door and over-temperature interlocks with a latched fault.
- All timing is in whole seconds derived from the 50 kHz system clock.

Parameters:
- CLK_PER_SEC, 50000, CLK cycles per second tick; minimum 2.
- SPINUP_SEC, 2, seconds motor runs unheated before the heater may engage.
- COOLDOWN_SEC, 5, seconds motor keeps running after heat is removed.
- SEC_W, 8, width of the seconds down-counter; must hold max(SPINUP_SEC, COOLDOWN_SEC).

Ports:
- CLK  in  1  system clock, 50 kHz.
- RESET_N  in  1  asynchronous, active-low reset.
- MTR_REQ  in  1  motor request from the controller; synchronous to CLK.
- HTR_REQ  in  2  heat request from the controller, [0:1] ordering (00 off, 01 lo, 10 med, 11 hi); synchronous to CLK.
- DOOR_OPEN  in  1  door switch; asynchronous, high = open.
- OVERTEMP  in  1  thermal sensor; asynchronous, high = over limit.
- FAULT_CLR  in  1  single-cycle fault acknowledge.
- MTR_DRV  out  1  motor relay.
- HTR_DRV  out  2  heater relay level, same encoding as HTR_REQ.
- COOLING  out  1  high while in COOLDOWN.
- FAULT  out  1  latched over-temperature fault.

Behaviour:
- Reset: async on RESET_N low. State=IDLE; MTR_DRV=0, HTR_DRV=00, COOLING=0, FAULT=0; synchronizers, prescaler, seconds counter and heat_used flag all cleared.
- Synchronizers: DOOR_OPEN and OVERTEMP each pass through a 2-flop synchronizer (door_s, temp_s), giving 2 cycles of input latency. All other inputs are used directly.
- Timebase:
  - Prescaler counts 0..CLK_PER_SEC-1 and emits sec_tick on the terminal count.
  - Prescaler restarts at 0 on every state entry.
  - A timed state therefore lasts exactly N*CLK_PER_SEC cycles, counted from the first cycle in the state.
- Outputs are registered. The values listed per state take effect the cycle after the state is entered.
- States:
  - IDLE: MTR_DRV=0, HTR_DRV=00.
    - MTR_REQ & !door_s & !temp_s -> SPINUP; load sec counter with SPINUP_SEC.
  - SPINUP: MTR_DRV=1, HTR_DRV=00.
    - Decrement sec counter on sec_tick; reaching 0 -> RUN.
    - MTR_REQ low -> IDLE (no heat was applied, so no cool-down).
  - RUN: MTR_DRV=1.
    - HTR_DRV tracks HTR_REQ with rate limiting:
      - HTR_REQ < HTR_DRV: HTR_DRV=HTR_REQ next cycle.
      - HTR_REQ > HTR_DRV: HTR_DRV increments by 1 on each sec_tick, never passing HTR_REQ.
    - heat_used is set whenever HTR_DRV != 00.
    - MTR_REQ low: if heat_used -> COOLDOWN (load COOLDOWN_SEC), else -> IDLE.
    - HTR_DRV is forced to 00 on exit.
  - COOLDOWN: MTR_DRV=1, HTR_DRV=00, COOLING=1.
    - Sec counter reaches 0 -> IDLE; heat_used cleared.
    - MTR_REQ high -> RUN directly: no re-spin-up, HTR_DRV restarts ramping from 00, heat_used kept.
  - FAULT: FAULT=1, HTR_DRV=00.
    - MTR_DRV=1 for COOLDOWN_SEC seconds, then 0; the sec counter is loaded on entry.
    - FAULT_CLR & !temp_s -> IDLE with FAULT=0.
    - FAULT_CLR while temp_s is high is ignored.
- Interlocks, applied in every state and taking priority over everything above:
  - temp_s high in SPINUP/RUN/COOLDOWN -> FAULT. temp_s high in IDLE -> FAULT.
  - door_s high in SPINUP/RUN/COOLDOWN -> IDLE immediately, with MTR_DRV=0 and HTR_DRV=00 next cycle and heat_used cleared. There is no cool-down with the door open.
  - door_s high in FAULT: MTR_DRV=0 while open; the cool-down count continues.
  - temp_s and door_s high together: FAULT wins, and MTR_DRV=0 because the door is open.
- Heater is never non-zero unless MTR_DRV=1 in the same cycle; checked by assertion.
- Sec counter width is SEC_W. A parameter value of 0 for SPINUP_SEC or COOLDOWN_SEC means the state lasts 1 cycle.

Test Plan:
Common settings: CLK_PER_SEC=10, SPINUP_SEC=2, COOLDOWN_SEC=3.
1. Nominal start with ramp: MTR_REQ=1, HTR_REQ=11.
   - MTR_DRV=1 one cycle later; HTR_DRV=00 for 20 cycles.
   - After RUN entry, HTR_DRV steps 01 -> 10 -> 11 at +10, +20, +30 cycles.
2. Stop with cool-down: in RUN with HTR_DRV=11, drop MTR_REQ.
   - Next cycle HTR_DRV=00, COOLING=1, MTR_DRV=1 for 30 cycles, then MTR_DRV=0, COOLING=0.
3. Unheated stop: in RUN with HTR_REQ held 00, drop MTR_REQ -> IDLE next cycle, MTR_DRV=0, COOLING never asserted.
4. Door interlock: assert DOOR_OPEN in RUN at HTR_DRV=10 -> MTR_DRV=0 and HTR_DRV=00 within 3 cycles; MTR_REQ=1 still held, so the block waits in IDLE until the door closes, then re-enters SPINUP.
5. Over-temperature fault:
   - Assert OVERTEMP in RUN -> FAULT=1, HTR_DRV=00 within 3 cycles; MTR_DRV=1 for 30 cycles, then 0.
   - FAULT_CLR while OVERTEMP=1 -> no change.
   - Drop OVERTEMP, wait 2 cycles, pulse FAULT_CLR -> FAULT=0, IDLE.
6. Reset mid-run: pulse RESET_N low asynchronously between clock edges in RUN at HTR_DRV=11 -> all outputs 0 immediately; after release with MTR_REQ=1, the full 20-cycle spin-up repeats.
